tx_packet_framer: RTL and testbench
===================================

// Module: tx_packet_framer
// PURPOSE
//  Byte-level USB full-speed TX framer; sits directly downstream of data_buffer.
//  - On a packet command, emits SYNC and PID, then (data packets only) the payload and CRC16.
//  - Payload bytes are pulled from data_buffer via get_tx_packet_data/tx_packet_data.
//  - Output bytes go over a valid/ready handshake to the bit-stuff/NRZI serializer.
// PARAMETERS
//  MAX_PAYLOAD  64  largest data payload in bytes; a larger occupancy is an error
// PORTS
//  clk                 in   1  system clock
//  n_rst               in   1  asynchronous active-low reset
//  tx_packet           in   3  command, sampled in IDLE only: 0 none,1 DATA0,2 DATA1,3 ACK,4 NAK,5 STALL
//  buffer_occupancy    in   7  bytes held in data_buffer
//  tx_packet_data      in   8  byte from data_buffer, valid the cycle after get is sampled high
//  get_tx_packet_data  out  1  one-cycle pop request to data_buffer
//  byte_out            out  8  byte to serializer
//  byte_valid          out  1  byte_out valid
//  byte_ready          in   1  serializer accepts; transfer = valid&ready at posedge
//  byte_last           out  1  qualifies final byte of the packet (serializer appends EOP)
//  tx_transfer_active  out  1  high from command accept until the last byte transfers
//  tx_done             out  1  one-cycle pulse after the last byte transfers
//  tx_error            out  1  one-cycle pulse on rejected command
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in IDLE; CRC reg 16'hFFFF; byte counter 0. Async reset mid-packet aborts immediately.
//  - FSM states: IDLE, SYNC, PID, FETCH, WAIT, DATA, CRC_LO, CRC_HI, DONE.
//  - IDLE, tx_packet in 1..5:
//    - latch cmd and count = buffer_occupancy.
//    - data cmd with count > MAX_PAYLOAD: tx_error pulse, stay IDLE, nothing sent.
//    - otherwise go to SYNC.
//  - IDLE, tx_packet 6/7: tx_error pulse, stay IDLE.
//  - Commands outside IDLE are ignored.
//  - SYNC: byte_out 8'h80. PID: 8'hC3/4B/D2/5A/1E for DATA0/DATA1/ACK/NAK/STALL.
//  - Handshake packets (ACK/NAK/STALL): PID byte carries byte_last; after transfer -> DONE.
//  - Data packets, after the PID transfers:
//    - count==0 -> CRC_LO; else -> FETCH.
//    - FETCH asserts get for exactly one cycle -> WAIT; WAIT registers tx_packet_data into byte_out -> DATA.
//    - On DATA transfer: CRC updated, count decremented; count hits 0 -> CRC_LO, else FETCH.
//  - CRC16-USB: reflected poly 16'hA001, init 16'hFFFF, byte-serial LSB-first update.
//    - CRC_LO sends ~crc[7:0]; CRC_HI sends ~crc[15:8] with byte_last.
//  - Stall: while byte_valid & !byte_ready, byte_out/byte_valid/byte_last hold stable; no get issued.
//  - DONE: tx_done pulse, tx_transfer_active drops the same cycle, CRC reinit, -> IDLE.
//    - Next command is accepted the following cycle.
//  - byte_valid high only in SYNC, PID, DATA, CRC_LO, CRC_HI.
// CONFIGURATION
//  - TX_FRAMER_STATS_EN defined:
//    - adds output tx_pkt_count[15:0], reset 0.
//    - increments on every tx_done; wraps 16'hFFFF->0.
//  - Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - usb_pkg: tx_packet_t enum, PID_* byte constants, SYNC_BYTE, CRC16_POLY/CRC16_INIT, state typedef.
//  - One sub-module: usb_crc16_byte (combinational next-CRC from crc_in and data byte; reused by RX CRC check).
// TESTING
//  - ACK, byte_ready=1 -> bytes 80,D2; last on D2; tx_done 1 cycle after; no get pulses.
//  - DATA1, occupancy 0 -> 80,4B,00,00; last on 2nd 00; zero get pulses.
//  - DATA0, occupancy 1, buffer byte 00 -> 80,C3,00,40,BF; exactly one get; last on BF.
//  - DATA0, 64 bytes, byte_ready toggling every cycle -> 64 gets, 68 bytes total, outputs stable while stalled, CRC matches model.
//  - DATA0 with occupancy 65; tx_packet=7 in IDLE -> tx_error pulse each, no byte_valid, active stays 0.
//  - n_rst low mid-payload -> all outputs 0 at once; fresh ACK afterwards frames correctly; stats build: count ++ per tx_done only.

Source files
------------

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - USB TX framer shared types, PID/SYNC bytes and CRC16 constants
package usb_pkg;

  typedef enum logic [2:0] {
    TX_NONE  = 3'd0,
    TX_DATA0 = 3'd1,
    TX_DATA1 = 3'd2,
    TX_ACK   = 3'd3,
    TX_NAK   = 3'd4,
    TX_STALL = 3'd5
  } tx_packet_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_FETCH,
    ST_WAIT,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_DONE
  } tx_state_t;

  localparam logic [7:0]  SYNC_BYTE  = 8'h80;
  localparam logic [7:0]  PID_DATA0  = 8'hC3;
  localparam logic [7:0]  PID_DATA1  = 8'h4B;
  localparam logic [7:0]  PID_ACK    = 8'hD2;
  localparam logic [7:0]  PID_NAK    = 8'h5A;
  localparam logic [7:0]  PID_STALL  = 8'h1E;
  localparam logic [15:0] CRC16_POLY = 16'hA001;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic logic [7:0] pid_byte(input tx_packet_t p);
    case (p)
      TX_DATA0: return PID_DATA0;
      TX_DATA1: return PID_DATA1;
      TX_ACK:   return PID_ACK;
      TX_NAK:   return PID_NAK;
      TX_STALL: return PID_STALL;
      default:  return 8'h00;
    endcase
  endfunction

  function automatic logic is_data(input tx_packet_t p);
    return (p == TX_DATA0) || (p == TX_DATA1);
  endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// rtl/usb_crc16_byte.sv - combinational CRC16-USB next value for one byte, LSB first
module usb_crc16_byte
  import usb_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] acc;

  always_comb begin
    acc = crc_i ^ {8'h00, data_i};
    for (int i = 0; i < 8; i++) begin
      acc = acc[0] ? ((acc >> 1) ^ CRC16_POLY) : (acc >> 1);
    end
    crc_o = acc;
  end

endmodule

// File: rtl/tx_packet_framer.sv
// rtl/tx_packet_framer.sv - USB FS byte framer: SYNC, PID, payload, CRC16 to serializer
// Optional packet counter output enabled by defining TX_FRAMER_STATS_EN.
module tx_packet_framer
  import usb_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [2:0]  tx_packet,
  input  logic [6:0]  buffer_occupancy,
  input  logic [7:0]  tx_packet_data,
  output logic        get_tx_packet_data,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        byte_last,
  output logic        tx_transfer_active,
  output logic        tx_done,
  output logic        tx_error
`ifdef TX_FRAMER_STATS_EN
  ,
  output logic [15:0] tx_pkt_count
`endif
);

  localparam logic [6:0] MAX_OCC = 7'(MAX_PAYLOAD);

  tx_state_t   state_q;
  tx_packet_t  cmd_q;
  logic [6:0]  count_q;
  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic [7:0]  byte_out_q;
  logic        valid_q;
  logic        last_q;
  logic        get_q;
  logic        active_q;
  logic        done_q;
  logic        error_q;
  logic        xfer;
  tx_packet_t  cmd_in;
`ifdef TX_FRAMER_STATS_EN
  logic [15:0] pkt_count_q;
  assign tx_pkt_count = pkt_count_q;
`endif

  assign xfer   = valid_q & byte_ready;
  assign cmd_in = tx_packet_t'(tx_packet);

  usb_crc16_byte u_crc (
    .crc_i  (crc_q),
    .data_i (byte_out_q),
    .crc_o  (crc_d)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= TX_NONE;
      count_q    <= '0;
      crc_q      <= CRC16_INIT;
      byte_out_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      get_q      <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef TX_FRAMER_STATS_EN
      pkt_count_q <= '0;
`endif
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      get_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tx_packet != 3'd0) begin
            cmd_q   <= cmd_in;
            count_q <= buffer_occupancy;
            if (tx_packet > 3'd5 || (is_data(cmd_in) && buffer_occupancy > MAX_OCC)) begin
              error_q <= 1'b1;
            end else begin
              state_q    <= ST_SYNC;
              byte_out_q <= SYNC_BYTE;
              valid_q    <= 1'b1;
              active_q   <= 1'b1;
            end
          end
        end
        ST_SYNC: begin
          if (xfer) begin
            state_q    <= ST_PID;
            byte_out_q <= pid_byte(cmd_q);
            last_q     <= !is_data(cmd_q);
          end
        end
        ST_PID: begin
          if (xfer) begin
            if (!is_data(cmd_q)) begin
              state_q    <= ST_DONE;
              byte_out_q <= '0;
              valid_q    <= 1'b0;
              last_q     <= 1'b0;
              active_q   <= 1'b0;
              done_q     <= 1'b1;
            end else if (count_q == 7'd0) begin
              state_q    <= ST_CRC_LO;
              byte_out_q <= ~crc_q[7:0];
            end else begin
              state_q <= ST_FETCH;
              valid_q <= 1'b0;
              get_q   <= 1'b1;
            end
          end
        end
        ST_FETCH: state_q <= ST_WAIT;
        // data_buffer presents the popped byte during this cycle
        ST_WAIT: begin
          state_q    <= ST_DATA;
          byte_out_q <= tx_packet_data;
          valid_q    <= 1'b1;
        end
        ST_DATA: begin
          if (xfer) begin
            crc_q   <= crc_d;
            count_q <= count_q - 7'd1;
            if (count_q == 7'd1) begin
              state_q    <= ST_CRC_LO;
              byte_out_q <= ~crc_d[7:0];
            end else begin
              state_q <= ST_FETCH;
              valid_q <= 1'b0;
              get_q   <= 1'b1;
            end
          end
        end
        ST_CRC_LO: begin
          if (xfer) begin
            state_q    <= ST_CRC_HI;
            byte_out_q <= ~crc_q[15:8];
            last_q     <= 1'b1;
          end
        end
        ST_CRC_HI: begin
          if (xfer) begin
            state_q    <= ST_DONE;
            byte_out_q <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          crc_q   <= CRC16_INIT;
`ifdef TX_FRAMER_STATS_EN
          pkt_count_q <= pkt_count_q + 16'd1;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign get_tx_packet_data = get_q;
  assign byte_out           = byte_out_q;
  assign byte_valid         = valid_q;
  assign byte_last          = last_q;
  assign tx_transfer_active = active_q;
  assign tx_done            = done_q;
  assign tx_error           = error_q;

endmodule

// File: tb/tb_tx_packet_framer.sv
// tb/tb_tx_packet_framer.sv - self-checking bench for tx_packet_framer
module tb_tx_packet_framer;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [2:0] tx_packet = 3'd0;
  logic [6:0] buffer_occupancy = 7'd0;
  logic [7:0] tx_packet_data = 8'd0;
  logic       byte_ready = 1'b0;
  logic       get_tx_packet_data;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_last;
  logic       tx_transfer_active;
  logic       tx_done;
  logic       tx_error;
`ifdef TX_FRAMER_STATS_EN
  logic [15:0] tx_pkt_count;
`endif

  always #5 clk = ~clk;

  tx_packet_framer dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_packet          (tx_packet),
    .buffer_occupancy   (buffer_occupancy),
    .tx_packet_data     (tx_packet_data),
    .get_tx_packet_data (get_tx_packet_data),
    .byte_out           (byte_out),
    .byte_valid         (byte_valid),
    .byte_ready         (byte_ready),
    .byte_last          (byte_last),
    .tx_transfer_active (tx_transfer_active),
    .tx_done            (tx_done),
    .tx_error           (tx_error)
`ifdef TX_FRAMER_STATS_EN
    ,
    .tx_pkt_count       (tx_pkt_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  int gets_total = 0;
  int done_seen = 0;
  logic [7:0] bufq[$];
  logic [7:0] payload[$];
  logic [7:0] exp_q[$];

  typedef struct {
    int cmd;
    int occ;
    int rmode;
    bit noise;
    bit exp_err;
    int exp_len;
  } vec_t;

  vec_t vecs[12];

  // data_buffer stand-in: pop on a get request, byte stays until the next pop
  always @(negedge clk) begin
    if (n_rst && get_tx_packet_data) begin
      gets_total++;
      tx_packet_data = (bufq.size() > 0) ? bufq.pop_front() : 8'h00;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_pid(input int cmd);
    logic [7:0] pids[6] = '{8'h00, 8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h1E};
    return pids[cmd];
  endfunction

  // Expected wire bytes from the protocol rules: SYNC, PID, payload, inverted CRC16 LSB first
  task automatic build_expected(input int cmd);
    logic [15:0] crc;
    logic fb;
    exp_q.delete();
    exp_q.push_back(8'h80);
    exp_q.push_back(model_pid(cmd));
    if (cmd == 1 || cmd == 2) begin
      crc = 16'hFFFF;
      foreach (payload[k]) begin
        exp_q.push_back(payload[k]);
        for (int b = 0; b < 8; b++) begin
          fb  = crc[0] ^ payload[k][b];
          crc = crc >> 1;
          if (fb) crc = crc ^ 16'hA001;
        end
      end
      crc = ~crc;
      exp_q.push_back(crc[7:0]);
      exp_q.push_back(crc[15:8]);
    end
  endtask

  task automatic run_packet(input vec_t v, input bit zero_payload);
    logic [7:0] got[$];
    bit is_data;
    bit stalled;
    bit rdy;
    logic [7:0] p_out;
    logic p_last;
    int g0, nlast, last_cyc, last_idx, done_cyc, act_bad, err_bad, stall_bad, n;
    is_data = (v.cmd == 1 || v.cmd == 2);
    payload.delete();
    if (is_data && !v.exp_err)
      for (int i = 0; i < v.occ; i++)
        payload.push_back(zero_payload ? 8'h00 : 8'($urandom_range(0, 255)));
    bufq = payload;
    build_expected(v.cmd);
    g0 = gets_total;
    tx_packet = 3'(v.cmd);
    buffer_occupancy = 7'(v.occ);
    byte_ready = (v.rmode == 0);
    @(posedge clk); #1;
    tx_packet = 3'd0;
    if (v.exp_err) begin
      chk("err_pulse", tx_error, 1);
      chk("err_no_valid", byte_valid, 0);
      chk("err_no_active", tx_transfer_active, 0);
      @(posedge clk); #1;
      chk("err_one_cycle", tx_error, 0);
      chk("err_no_valid2", byte_valid, 0);
      chk("err_no_get", gets_total - g0, 0);
      return;
    end
    chk("accept_no_err", tx_error, 0);
    stalled = 0; p_out = 0; p_last = 0;
    nlast = 0; last_cyc = -10; last_idx = -1; done_cyc = -1;
    act_bad = 0; err_bad = 0; stall_bad = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (tx_done) begin
        done_cyc = cyc;
        break;
      end
      if (!tx_transfer_active) act_bad++;
      if (tx_error) err_bad++;
      if (stalled && (byte_out !== p_out || byte_valid !== 1'b1 || byte_last !== p_last || get_tx_packet_data))
        stall_bad++;
      rdy = (v.rmode == 0) ? 1'b1 : (v.rmode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      byte_ready = rdy;
      tx_packet = (v.noise && byte_valid && !byte_last) ? 3'($urandom_range(1, 7)) : 3'd0;
      if (byte_valid && rdy) begin
        got.push_back(byte_out);
        if (byte_last) begin
          nlast++;
          last_cyc = cyc;
          last_idx = got.size() - 1;
        end
      end
      stalled = byte_valid && !rdy;
      p_out = byte_out;
      p_last = byte_last;
      @(posedge clk); #1;
    end
    tx_packet = 3'd0;
    if (done_cyc < 0) begin
      chk("done_timeout", 0, 1);
      return;
    end
    done_seen++;
    chk("byte_count", got.size(), exp_q.size());
    if (v.exp_len > 0) chk("byte_count_fixed", got.size(), v.exp_len);
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("byte[%0d]", i), got[i], exp_q[i]);
    chk("last_once", nlast, 1);
    chk("last_on_final", last_idx, got.size() - 1);
    chk("done_after_last", done_cyc, last_cyc + 1);
    chk("active_held", act_bad, 0);
    chk("no_err_in_pkt", err_bad, 0);
    chk("stall_stable", stall_bad, 0);
    chk("get_count", gets_total - g0, is_data ? v.occ : 0);
    chk("active_drop_at_done", tx_transfer_active, 0);
    if (zero_payload && v.occ == 1 && got.size() == 5) begin
      chk("crc_lo_literal", got[3], 8'h40);
      chk("crc_hi_literal", got[4], 8'hBF);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", tx_done, 0);
  endtask

  initial begin
    vec_t rv;
    vecs[0]  = '{3, 0, 0, 0, 0, 2};
    vecs[1]  = '{2, 0, 0, 0, 0, 4};
    vecs[2]  = '{1, 1, 0, 0, 0, 5};
    vecs[3]  = '{4, 0, 1, 0, 0, 2};
    vecs[4]  = '{5, 7, 2, 1, 0, 2};
    vecs[5]  = '{1, 64, 1, 0, 0, 68};
    vecs[6]  = '{2, 3, 2, 1, 0, 7};
    vecs[7]  = '{1, 65, 0, 0, 1, 0};
    vecs[8]  = '{2, 127, 0, 0, 1, 0};
    vecs[9]  = '{3, 100, 0, 0, 0, 2};
    vecs[10] = '{7, 0, 0, 0, 1, 0};
    vecs[11] = '{6, 5, 0, 0, 1, 0};

    #2;
    chk("rst_valid", byte_valid, 0);
    chk("rst_active", tx_transfer_active, 0);
    chk("rst_get", get_tx_packet_data, 0);
    chk("rst_byte_out", byte_out, 0);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_valid", byte_valid, 0);
    chk("idle_done", tx_done, 0);
    chk("idle_error", tx_error, 0);
    chk("idle_last", byte_last, 0);

    foreach (vecs[i]) run_packet(vecs[i], i == 2);

    for (int r = 0; r < 25; r++) begin
      rv.cmd = $urandom_range(1, 5);
      rv.occ = $urandom_range(0, 64);
      rv.rmode = $urandom_range(0, 2);
      rv.noise = 1'($urandom_range(0, 1));
      rv.exp_err = 0;
      rv.exp_len = 0;
      run_packet(rv, 0);
    end

    // asynchronous reset in the middle of a payload
    payload.delete();
    for (int i = 0; i < 20; i++) payload.push_back(8'($urandom_range(0, 255)));
    bufq = payload;
    tx_packet = 3'd1;
    buffer_occupancy = 7'd20;
    byte_ready = 1'b1;
    @(posedge clk); #1;
    tx_packet = 3'd0;
    repeat (15) @(posedge clk);
    #1;
    chk("midpkt_active", tx_transfer_active, 1);
    n_rst = 1'b0;
    #1;
    chk("arst_valid", byte_valid, 0);
    chk("arst_byte_out", byte_out, 0);
    chk("arst_last", byte_last, 0);
    chk("arst_get", get_tx_packet_data, 0);
    chk("arst_active", tx_transfer_active, 0);
    chk("arst_done", tx_done, 0);
    chk("arst_error", tx_error, 0);
`ifdef TX_FRAMER_STATS_EN
    chk("arst_count", tx_pkt_count, 0);
`endif
    done_seen = 0;
    bufq.delete();
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    run_packet(vecs[0], 0);
    run_packet(vecs[7], 0);
    @(posedge clk); #1;
`ifdef TX_FRAMER_STATS_EN
    chk("pkt_count", tx_pkt_count, 16'(done_seen));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
